// File: rtl/pcie_symbols.sv
// Shared PCIe receive-path symbol set: K-codes, link width encodings and framing FSM states.
package pcie_symbols;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_PAD = 8'hF7;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_IDL = 8'h7C;

  typedef enum logic [1:0] {
    WIDTH_X1     = 2'b00,
    WIDTH_X2     = 2'b01,
    WIDTH_X4     = 2'b10,
    WIDTH_X4_ALT = 2'b11
  } width_e;

  typedef enum logic {
    ST_IDLE,
    ST_PKT
  } frame_state_e;

  function automatic logic [1:0] last_lane(width_e w);
    case (w)
      WIDTH_X1: return 2'd0;
      WIDTH_X2: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

  function automatic logic is_start(logic [7:0] b);
    return (b == K_STP) || (b == K_SDP);
  endfunction

  // Symbols that may legally sit between packets.
  function automatic logic is_filler(logic [7:0] b);
    return (b == K_IDL) || (b == K_PAD) || (b == K_SKP) || (b == K_COM) || (b == K_FTS);
  endfunction

endpackage

// File: rtl/unstriping_ctrl_if.sv
// Lane-group handshake from the deskew stage into the un-striping controller.
interface unstriping_ctrl_if;
  logic [7:0] FL0, FL1, FL2, FL3;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] link_width;

  modport master (output FL0, FL1, FL2, FL3, in_valid, link_width, input in_ready);
  modport slave  (input FL0, FL1, FL2, FL3, in_valid, link_width, output in_ready);
endinterface

// File: rtl/lane_group_buf.sv
// One-deep lane group buffer: holds an accepted group and presents its active lanes one per cycle.
module lane_group_buf
  import pcie_symbols::*;
(
  input  logic              clk,
  input  logic              reset,
  unstriping_ctrl_if.slave  in_if,
  output logic              cur_valid,
  output logic [1:0]        cur_lane,
  output logic [7:0]        cur_byte
);

  logic [3:0][7:0] data_q, data_d;
  width_e          width_q, width_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            full_q, full_d;
  logic            at_last;
  logic            accept;

  assign at_last        = (ptr_q == last_lane(width_q));
  assign in_if.in_ready = !reset && (!full_q || at_last);
  assign accept         = in_if.in_valid && in_if.in_ready;

  assign cur_valid = full_q;
  assign cur_lane  = ptr_q;
  assign cur_byte  = data_q[ptr_q];

  always_comb begin
    // NOTE: every combinational output is defaulted first, so no branch can leave a latch behind.
    data_d  = data_q;
    width_d = width_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    if (full_q) begin
      if (at_last) begin
        full_d = 1'b0;
        ptr_d  = 2'd0;
      end else begin
        ptr_d = ptr_q + 2'd1;
      end
    end
    // A new group may land on the same edge the last lane of the old one is consumed.
    if (accept) begin
      data_d  = {in_if.FL3, in_if.FL2, in_if.FL1, in_if.FL0};
      width_d = width_e'(in_if.link_width);
      full_d  = 1'b1;
      ptr_d   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      full_q <= 1'b0;
      ptr_q  <= 2'd0;
    end else begin
      full_q <= full_d;
      ptr_q  <= ptr_d;
    end
  end

  // NOTE: payload storage is not reset; it is only ever read while full_q qualifies it.
  always_ff @(posedge clk) begin
    data_q  <= data_d;
    width_q <= width_d;
  end

endmodule

// File: rtl/unstriping_ctrl.sv
// Receive un-striping controller: sequences buffered lanes in order and tracks STP/SDP..END/EDB framing.
module unstriping_ctrl
  import pcie_symbols::*;
#(
  parameter int MAX_LEN = 1024
) (
  input  logic              clk,
  input  logic              reset,
  unstriping_ctrl_if.slave  in_if,
  output logic [1:0]        lane_sel,
  output logic [7:0]        toDemux,
  output logic              out_valid,
  output logic              sop,
  output logic              eop,
  output logic              nullify,
  output logic              err
);

  localparam int              CNT_W     = 11;
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] LEN_LIMIT = CNT_W'(MAX_LEN);

  typedef struct packed {
    logic [1:0] lane_sel;
    logic [7:0] data;
    logic       valid;
    logic       sop;
    logic       eop;
    logic       nullify;
    logic       err;
  } out_t;

  logic             cur_valid;
  logic [1:0]       cur_lane;
  logic [7:0]       cur_byte;
  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  out_t             out_q, out_d;
  logic             fwd;

  lane_group_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_if     (in_if),
    .cur_valid (cur_valid),
    .cur_lane  (cur_lane),
    .cur_byte  (cur_byte)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fwd           = 1'b0;
    out_d         = out_q;
    out_d.valid   = 1'b0;
    out_d.sop     = 1'b0;
    out_d.eop     = 1'b0;
    out_d.nullify = 1'b0;
    out_d.err     = 1'b0;
    if (cur_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_start(cur_byte)) begin
            fwd       = 1'b1;
            out_d.sop = 1'b1;
            cnt_d     = CNT_W'(1);
            state_d   = ST_PKT;
          end else if (!is_filler(cur_byte)) begin
            out_d.err = 1'b1;
          end
        end
        ST_PKT: begin
          case (cur_byte)
            K_END: begin
              fwd       = 1'b1;
              out_d.eop = 1'b1;
              state_d   = ST_IDLE;
            end
            K_EDB: begin
              fwd           = 1'b1;
              out_d.eop     = 1'b1;
              out_d.nullify = 1'b1;
              state_d       = ST_IDLE;
            end
            // A fresh start truncates the open packet but still opens a new one.
            K_STP, K_SDP: begin
              fwd       = 1'b1;
              out_d.sop = 1'b1;
              out_d.err = 1'b1;
              cnt_d     = CNT_W'(1);
            end
            K_IDL, K_PAD: begin
              out_d.err = 1'b1;
              state_d   = ST_IDLE;
            end
            K_SKP, K_COM, K_FTS: ;
            default: begin
              if (cnt_q >= LEN_LIMIT) begin
                out_d.err = 1'b1;
                state_d   = ST_IDLE;
              end else begin
                fwd   = 1'b1;
                cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
              end
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (fwd) begin
      out_d.valid    = 1'b1;
      out_d.data     = cur_byte;
      out_d.lane_sel = cur_lane;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign lane_sel  = out_q.lane_sel;
  assign toDemux   = out_q.data;
  assign out_valid = out_q.valid;
  assign sop       = out_q.sop;
  assign eop       = out_q.eop;
  assign nullify   = out_q.nullify;
  assign err       = out_q.err;

endmodule
